// File: rtl/sipo_pkg.sv
// sipo_pkg: shared types and width helpers for the SIPO receiver slice.
//   state_t    - receiver FSM states (IDLE, RECV)
//   cnt_w()    - bit-count width for a WIDTH-bit word: clog2(WIDTH+1)
//   gap_w()    - idle gap-counter width for a timeout: clog2(TIMEOUT+1)
package sipo_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RECV = 1'b1
    } state_t;

    function automatic int cnt_w(input int width);
        return $clog2(width + 1);
    endfunction

    function automatic int gap_w(input int timeout);
        return $clog2(timeout + 1);
    endfunction

    localparam int DEF_WIDTH   = 8;
    localparam int DEF_TIMEOUT = 16;
    localparam int DEF_CNT_W   = $clog2(DEF_WIDTH + 1);
    localparam int DEF_GAP_W   = $clog2(DEF_TIMEOUT + 1);

endpackage

// File: rtl/sipo_gap_timer.sv
// sipo_gap_timer: idle-cycle counter used to time out stalled partial words.
//   clk, rst_n - clock, synchronous active-low reset
//   clear      - load the counter with zero (wins over enable)
//   enable     - count one idle cycle
//   expired    - counter has reached TIMEOUT
module sipo_gap_timer
    import sipo_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int GW = gap_w(TIMEOUT);

    logic [GW-1:0] gap;

    assign expired = (gap == GW'(TIMEOUT));

    // Holds at TIMEOUT until cleared so the count can never wrap.
    always_ff @(posedge clk) begin
        if (!rst_n)
            gap <= '0;
        else if (clear)
            gap <= '0;
        else if (enable && !expired)
            gap <= gap + 1'b1;
    end

endmodule

// File: rtl/sipo_rx.sv
// sipo_rx: serial-in/parallel-out receiver behind the PISO serializer.
//   clk, rst_n - clock, synchronous active-low reset
//   In/Valid_i - serial bit and its qualifier
//   Out/Valid_o- assembled word, held until Ack_i
//   Ack_i      - consumer takes Out (ignored while Valid_o=0)
//   Overrun_o  - sticky: completed word dropped because Out was full
//   Drop_o     - one-cycle pulse: partial word discarded by gap timeout
module sipo_rx
    import sipo_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int MSB_FIRST = 0,
    parameter int TIMEOUT   = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             In,
    input  logic             Valid_i,
    output logic [WIDTH-1:0] Out,
    output logic             Valid_o,
    input  logic             Ack_i,
    output logic             Overrun_o,
    output logic             Drop_o
);

    localparam int CW = cnt_w(WIDTH);

    state_t           state, state_n;
    logic [CW-1:0]    cnt, cnt_n, base_cnt;
    logic [WIDTH-1:0] sr, sr_n, base_sr, shifted;
    logic             expired, timeout, complete, ack_acc;

    sipo_gap_timer #(.TIMEOUT(TIMEOUT)) u_gap (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   ((state != RECV) || Valid_i || timeout),
        .enable  ((state == RECV) && !Valid_i),
        .expired (expired)
    );

    // Timeout discards the partial word, yet a bit arriving in the same
    // cycle must start a fresh word, so shifting works from a zeroed base.
    assign timeout  = (state == RECV) && expired;
    assign base_sr  = (timeout || state == IDLE) ? '0 : sr;
    assign base_cnt = timeout ? '0 : cnt;
    assign complete = Valid_i && (base_cnt == CW'(WIDTH - 1));
    assign ack_acc  = Valid_o && Ack_i;

    generate
        if (MSB_FIRST != 0) begin : g_msb
            assign shifted = (base_sr << 1) | WIDTH'(In);
        end else begin : g_lsb
            assign shifted = (base_sr >> 1) | {In, {(WIDTH-1){1'b0}}};
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            sr    <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            sr    <= sr_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        sr_n    = sr;
        if (timeout) begin
            state_n = IDLE;
            cnt_n   = '0;
            sr_n    = '0;
        end
        if (Valid_i) begin
            if (complete) begin
                state_n = IDLE;
                cnt_n   = '0;
                sr_n    = '0;
            end else begin
                state_n = RECV;
                cnt_n   = base_cnt + 1'b1;
                sr_n    = shifted;
            end
        end
    end

    // An ack in the completion cycle frees Out in time, so the new word
    // loads and no overrun is flagged.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            Out       <= '0;
            Valid_o   <= 1'b0;
            Overrun_o <= 1'b0;
            Drop_o    <= 1'b0;
        end else begin
            if (complete && (!Valid_o || ack_acc)) begin
                Out     <= shifted;
                Valid_o <= 1'b1;
            end else if (ack_acc) begin
                Valid_o <= 1'b0;
            end
            Overrun_o <= ack_acc ? 1'b0 : (Overrun_o | (complete & Valid_o));
            Drop_o    <= timeout;
        end
    end

endmodule

// File: tb/tb_sipo_rx.sv
module tb_sipo_rx;

    localparam int W   = 8;
    localparam int TMO = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         din = 1'b0, vin = 1'b0, ack = 1'b0;
    logic [W-1:0] out_l, out_m;
    logic         vld_l, vld_m, ovr_l, ovr_m, drp_l, drp_m;

    int checks = 0;
    int failures = 0;
    int drops = 0;

    // reference model: bits collected in arrival order
    int           q[$];
    int           idle = 0;
    logic [W-1:0] m_out_l = '0, m_out_m = '0;
    logic         m_vld = 1'b0, m_ovr = 1'b0, m_drp = 1'b0;

    always #5 clk = ~clk;

    sipo_rx #(.WIDTH(W), .MSB_FIRST(0), .TIMEOUT(TMO)) dut_l (
        .clk(clk), .rst_n(rst_n), .In(din), .Valid_i(vin), .Out(out_l),
        .Valid_o(vld_l), .Ack_i(ack), .Overrun_o(ovr_l), .Drop_o(drp_l)
    );

    sipo_rx #(.WIDTH(W), .MSB_FIRST(1), .TIMEOUT(TMO)) dut_m (
        .clk(clk), .rst_n(rst_n), .In(din), .Valid_i(vin), .Out(out_m),
        .Valid_o(vld_m), .Ack_i(ack), .Overrun_o(ovr_m), .Drop_o(drp_m)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_step(input logic i, input logic v, input logic a, input logic r);
        logic         comp, exp_to, acc;
        logic [W-1:0] wl, wm;
        comp = 1'b0;
        wl = '0;
        wm = '0;
        if (!r) begin
            q.delete();
            idle = 0;
            m_out_l = '0; m_out_m = '0;
            m_vld = 1'b0; m_ovr = 1'b0; m_drp = 1'b0;
        end else begin
            acc    = m_vld && a;
            exp_to = (q.size() > 0) && (idle == TMO);
            if (exp_to) begin
                q.delete();
                idle = 0;
            end
            if (v) begin
                q.push_back(int'(i));
                idle = 0;
                if (q.size() == W) begin
                    comp = 1'b1;
                    for (int k = 0; k < W; k++) begin
                        wl[k]       = q[k][0];
                        wm[W-1-k]   = q[k][0];
                    end
                    q.delete();
                end
            end else if (q.size() > 0) begin
                idle++;
            end
            m_ovr = acc ? 1'b0 : (m_ovr | (comp & m_vld));
            if (comp && (!m_vld || acc)) begin
                m_out_l = wl;
                m_out_m = wm;
                m_vld   = 1'b1;
            end else if (acc) begin
                m_vld = 1'b0;
            end
            m_drp = exp_to;
        end
    endtask

    task automatic cyc(input logic i, input logic v, input logic a);
        din = i; vin = v; ack = a;
        @(posedge clk);
        model_step(i, v, a, rst_n);
        #1;
        if (drp_l) drops++;
        chk("out_l", 32'(out_l), 32'(m_out_l));
        chk("vld_l", 32'(vld_l), 32'(m_vld));
        chk("ovr_l", 32'(ovr_l), 32'(m_ovr));
        chk("drp_l", 32'(drp_l), 32'(m_drp));
        chk("out_m", 32'(out_m), 32'(m_out_m));
        chk("vld_m", 32'(vld_m), 32'(m_vld));
        chk("ovr_m", 32'(ovr_m), 32'(m_ovr));
        chk("drp_m", 32'(drp_m), 32'(m_drp));
    endtask

    // bits go out w[0] first
    task automatic send_word(input logic [W-1:0] w, input logic ack_last);
        for (int k = 0; k < W; k++)
            cyc(w[k], 1'b1, (k == W-1) ? ack_last : 1'b0);
    endtask

    initial begin
        // reset
        rst_n = 1'b0;
        cyc(0, 0, 0);
        cyc(0, 0, 0);
        chk("rst_out", 32'(out_l), 0);
        chk("rst_vld", 32'(vld_l), 0);
        chk("rst_ovr", 32'(ovr_l), 0);
        chk("rst_drp", 32'(drp_l), 0);
        rst_n = 1'b1;
        cyc(0, 0, 0);

        // LSB-first word 1,1,1,1,0,0,0,1
        send_word(8'h8F, 1'b0);
        chk("lsb_8f_out", 32'(out_l), 32'h8F);
        chk("lsb_8f_vld", 32'(vld_l), 1);
        cyc(0, 0, 1);
        chk("lsb_ack_vld", 32'(vld_l), 0);

        // back-to-back with ack on the completing cycle
        send_word(8'h8F, 1'b0);
        send_word(8'hAA, 1'b1);
        chk("b2b_out", 32'(out_l), 32'hAA);
        chk("b2b_vld", 32'(vld_l), 1);
        chk("b2b_ovr", 32'(ovr_l), 0);
        cyc(0, 0, 1);

        // overrun
        send_word(8'h8F, 1'b0);
        send_word(8'h55, 1'b0);
        chk("ovr_out", 32'(out_l), 32'h8F);
        chk("ovr_flag", 32'(ovr_l), 1);
        cyc(0, 0, 1);
        chk("ovr_ack_vld", 32'(vld_l), 0);
        chk("ovr_ack_flag", 32'(ovr_l), 0);

        // timeout, new word starting on the expiry cycle
        drops = 0;
        cyc(1, 1, 0); cyc(0, 1, 0); cyc(1, 1, 0);
        for (int k = 0; k < TMO; k++) cyc(0, 0, 0);
        send_word(8'h3C, 1'b0);
        chk("to_drops", 32'(drops), 1);
        chk("to_out", 32'(out_l), 32'h3C);
        chk("to_vld", 32'(vld_l), 1);
        cyc(0, 0, 1);

        // timeout with the line staying idle afterwards
        drops = 0;
        cyc(1, 1, 0); cyc(1, 1, 0);
        for (int k = 0; k < TMO + 3; k++) cyc(0, 0, 0);
        chk("to2_drops", 32'(drops), 1);
        chk("to2_vld", 32'(vld_l), 0);

        // reset mid-word with a pending word held
        send_word(8'h8F, 1'b0);
        for (int k = 0; k < 5; k++) cyc(1'(k & 1), 1, 0);
        rst_n = 1'b0;
        cyc(1, 1, 1);
        chk("mrst_out", 32'(out_l), 0);
        chk("mrst_vld", 32'(vld_l), 0);
        chk("mrst_ovr", 32'(ovr_l), 0);
        chk("mrst_drp", 32'(drp_l), 0);
        rst_n = 1'b1;
        send_word(8'hC3, 1'b0);
        chk("mrst_c3", 32'(out_l), 32'hC3);
        cyc(0, 0, 1);

        // MSB-first: bits 1,0,0,0,1,1,1,1
        send_word(8'hF1, 1'b0);
        chk("msb_8f", 32'(out_m), 32'h8F);
        chk("msb_vld", 32'(vld_m), 1);
        cyc(0, 0, 1);

        // randomized traffic against the model
        for (int n = 0; n < 600; n++) begin
            rst_n = ($urandom_range(0, 249) != 0);
            cyc(1'($urandom_range(0, 1)),
                ($urandom_range(0, 99) < 65),
                ($urandom_range(0, 99) < 15));
        end
        rst_n = 1'b1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sipo_rx.md
# sipo_rx

Serial-in/parallel-out receiver stage that sits directly downstream of the PISO serializer. It samples the PISO serial `Out` / `Valid_o` stream one bit per qualified clock and reassembles WIDTH-bit words. Each completed word is presented on a held-valid/acknowledge output. The block adds gap-timeout recovery for stalled words and sticky overrun detection.

## Interface
- WIDTH, 8: word width in bits; valid range 2..32.
- MSB_FIRST, 0: 0 = first received bit is bit 0 (LSB-first); 1 = first received bit is bit WIDTH-1.
- TIMEOUT, 16: idle cycles allowed inside a partial word before it is discarded; must be ≥1.

- clk  in  1  single clock; all state changes on the rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- In  in  1  serial data bit; connects to PISO `Out`.
- Valid_i  in  1  In is a valid bit this cycle; connects to PISO `Valid_o`.
- Out  out  WIDTH  assembled word; stable while Valid_o=1.
- Valid_o  out  1  Out holds an unconsumed word (level, not pulse).
- Ack_i  in  1  consumer takes Out this cycle; ignored when Valid_o=0.
- Overrun_o  out  1  sticky: a completed word was dropped because Out was still full.
- Drop_o  out  1  one-cycle pulse: a partial word was discarded by timeout.

## Operation
- State machine, two states:
  - IDLE: bit count = 0. Valid_i=1 samples In, sets count=1, goes to RECV.
  - RECV: Valid_i=1 samples In and increments count. The gap counter clears on every qualified bit and increments on each Valid_i=0 cycle.
- Word completion: the qualified bit that brings count to WIDTH completes the word. Count returns to 0 and the state returns to IDLE.
- Output register:
  - On completion with Valid_o=0, or Valid_o=1 and Ack_i=1 in the same cycle: Out ← word, Valid_o ← 1.
  - On completion with Valid_o=1 and Ack_i=0: the new word is dropped, Out is unchanged, Overrun_o ← 1.
- Ack_i=1 with Valid_o=1 and no completion: Valid_o ← 0. Out keeps its last value.
- Overrun_o clears on the next accepted Ack_i. If an overrun and an Ack_i occur in the same cycle, Ack_i takes priority: the word loads and the flag is not set.
- Timeout: in RECV, when the gap counter reaches TIMEOUT, the partial word is discarded, the state returns to IDLE, and Drop_o pulses for 1 cycle. A qualified bit on that same cycle starts a new word at count=1.
- Bit placement:
  - MSB_FIRST=0: shift right, insert In at bit WIDTH-1. After WIDTH bits, the first bit is at bit 0.
  - MSB_FIRST=1: shift left, insert at bit 0.
- Reset (rst_n=0 at an edge), including mid-word:
  - State=IDLE, count=0, gap=0, shift register=0.
  - Out=0, Valid_o=0, Overrun_o=0, Drop_o=0.

## Timing
- Latency: Valid_o rises on the edge that samples the last bit, so it is high 1 cycle after the last Valid_i cycle.
- Back-to-back words with no gap are supported at 1 bit/cycle. Sustained throughput without overrun requires Ack_i at least once every WIDTH cycles.
- Ack_i takes effect on the edge where Valid_o=1 and Ack_i=1.
- Drop_o is registered and asserts 1 cycle after the TIMEOUT-th idle cycle.
- Combinational paths from inputs to outputs: none.

## Structure
- Package sipo_pkg holds:
  - the state enum {IDLE, RECV}
  - the count width constant: clog2(WIDTH+1)
  - the gap-counter width constant: clog2(TIMEOUT+1)
- One sub-module, sipo_gap_timer: a loadable idle counter.
  - Inputs: clear, enable.
  - Output: expired.
  - Instantiated once. Shift register, output register and FSM stay in sipo_rx.

## Test plan
- LSB-first word, default parameters: drive In = 1,1,1,1,0,0,0,1 with Valid_i=1 on 8 consecutive cycles. Required: Out=8'h8F, Valid_o=1 on the next cycle. Ack_i for 1 cycle clears Valid_o.
- Back-to-back with same-cycle ack: 8'hAA bits immediately follow 8'h8F, with Ack_i=1 on the completing cycle. Required: Out becomes 8'hAA, Valid_o stays 1, Overrun_o=0.
- Overrun: receive 8'h8F with no Ack, then 8'h55. Required: Out stays 8'h8F and Overrun_o=1. Then Ack_i: Valid_o=0, Overrun_o=0.
- Timeout (TIMEOUT=4): send 3 bits, hold Valid_i=0 for 4 cycles. Required: Drop_o pulses once, state returns to IDLE. A following full 8'h3C receives correctly.
- Reset mid-word: send 5 bits, rst_n=0 for 1 cycle, then send 8'hC3. Required: all outputs 0 during reset, then Out=8'hC3 with no residue from the partial word.
- MSB_FIRST=1: send bits 1,0,0,0,1,1,1,1. Required: Out=8'h8F.
